// File: rtl/lut4_cfg_ctrl_if.sv
// lut4_cfg_ctrl_if: LUT evaluate, serial-load and self-scan signal bundle
interface lut4_cfg_ctrl_if;
    logic [3:0]  x;
    logic        y;
    logic        cfg_start;
    logic        cfg_valid;
    logic        cfg_bit;
    logic        cfg_ready;
    logic        scan_start;
    logic        busy;
    logic        done;
    logic [15:0] readback;
    logic        readback_valid;
    modport master (
        output x, cfg_start, cfg_valid, cfg_bit, scan_start,
        input  y, cfg_ready, busy, done, readback, readback_valid
    );
    modport slave (
        input  x, cfg_start, cfg_valid, cfg_bit, scan_start,
        output y, cfg_ready, busy, done, readback, readback_valid
    );
endinterface

// File: rtl/lut4_cfg_ctrl.sv
// lut4_cfg_ctrl: 4-input LUT with atomic serial table load and self-scan readback
module lut4_cfg_ctrl #(
    parameter logic [15:0] INIT = 16'h0000
) (
    input logic clk,
    input logic rst,
    lut4_cfg_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SCAN = 2'd2;
    logic [1:0]  state;
    logic [15:0] lut_table;
    logic [15:0] shadow;
    logic [3:0]  cnt;
    assign bus.busy      = state != IDLE;
    assign bus.cfg_ready = state == LOAD;
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            lut_table          <= INIT;
            shadow             <= '0;
            cnt                <= '0;
            bus.y              <= 1'b0;
            bus.done           <= 1'b0;
            bus.readback       <= '0;
            bus.readback_valid <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE) begin
                bus.y <= lut_table[bus.x];
                if (bus.cfg_start || bus.scan_start) begin
                    state              <= bus.cfg_start ? LOAD : SCAN;
                    cnt                <= '0;
                    bus.readback_valid <= 1'b0;
                end
            end else if (state == LOAD) begin
                if (bus.cfg_valid) begin
                    shadow <= {shadow[14:0], bus.cfg_bit};
                    cnt    <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        lut_table <= {shadow[14:0], bus.cfg_bit};
                        bus.done  <= 1'b1;
                        state     <= IDLE;
                    end
                end
            end else if (state == SCAN) begin
                bus.readback[cnt] <= lut_table[cnt];
                cnt               <= cnt + 4'd1;
                if (cnt == 4'd15) begin
                    bus.readback_valid <= 1'b1;
                    bus.done           <= 1'b1;
                    state              <= IDLE;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_lut4_cfg_ctrl.sv
// tb_lut4_cfg_ctrl: directed plus randomized checks against a table-level reference model
module tb_lut4_cfg_ctrl;
    localparam logic [15:0] INIT = 16'hA5C3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] ref_table = INIT;
    logic [15:0] ref_rb = '0;
    logic        ref_rbv = 1'b0;
    lut4_cfg_ctrl_if bus();
    lut4_cfg_ctrl #(.INIT(INIT)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic noise();
        bus.cfg_start  = 1'($urandom);
        bus.scan_start = 1'($urandom);
        bus.x          = 4'($urandom);
    endtask
    task automatic quiet();
        bus.cfg_start  = 1'b0;
        bus.scan_start = 1'b0;
        bus.cfg_valid  = 1'b0;
    endtask
    task automatic probe(input logic [3:0] v);
        bus.x = v;
        tick();
        chk("y_eval", bus.y, ref_table[v]);
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_rbv", bus.readback_valid, ref_rbv);
    endtask
    task automatic load(input logic [15:0] v, input int gap, input bit both);
        logic held;
        bus.cfg_start  = 1'b1;
        bus.scan_start = both;
        tick();
        quiet();
        chk("load_busy", bus.busy, 1'b1);
        chk("load_ready", bus.cfg_ready, 1'b1);
        chk("load_rbv_clr", bus.readback_valid, 1'b0);
        chk("load_y_entry", bus.y, ref_table[bus.x]);
        held = bus.y;
        ref_rbv = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            for (int g = 0; g < gap; g++) begin
                noise();
                tick();
                quiet();
                chk("load_stall_ready", bus.cfg_ready, 1'b1);
            end
            noise();
            bus.cfg_valid = 1'b1;
            bus.cfg_bit   = v[i];
            tick();
            quiet();
            chk("load_done", bus.done, i == 0);
            chk("load_y_hold", bus.y, held);
            chk("load_ready_bit", bus.cfg_ready, i != 0);
        end
        ref_table = v;
        chk("load_busy_end", bus.busy, 1'b0);
        chk("load_rb_keep", bus.readback, ref_rb);
        tick();
        chk("load_done_pulse", bus.done, 1'b0);
    endtask
    task automatic scan();
        logic held;
        int n;
        bus.scan_start = 1'b1;
        tick();
        quiet();
        chk("scan_rbv_clr", bus.readback_valid, 1'b0);
        chk("scan_y_entry", bus.y, ref_table[bus.x]);
        held = bus.y;
        ref_rbv = 1'b0;
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            chk("scan_done_early", bus.done, 1'b0);
            noise();
            tick();
            quiet();
            chk("scan_y_hold", bus.y, held);
        end
        chk("scan_busy_cycles", 16'(n), 16'd16);
        ref_rb  = ref_table;
        ref_rbv = 1'b1;
        chk("scan_done", bus.done, 1'b1);
        chk("scan_readback", bus.readback, ref_rb);
        chk("scan_rbv", bus.readback_valid, 1'b1);
        tick();
        chk("scan_done_pulse", bus.done, 1'b0);
        chk("scan_rbv_keep", bus.readback_valid, 1'b1);
    endtask
    initial begin
        bus.x = '0;
        bus.cfg_bit = 1'b0;
        quiet();
        tick();
        tick();
        chk("rst_y", bus.y, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_ready", bus.cfg_ready, 1'b0);
        chk("rst_readback", bus.readback, 16'h0);
        chk("rst_rbv", bus.readback_valid, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) probe(4'(i));
        load(16'h8001, 2, 1'b0);
        probe(4'd0);
        probe(4'd15);
        probe(4'd7);
        chk("y_8001_x0", 16'(ref_table[0]), 16'd1);
        load(16'h6996, 0, 1'b0);
        scan();
        chk("scan_6996", bus.readback, 16'h6996);
        load(16'h3C5A, 1, 1'b1);
        chk("both_no_scan", bus.readback, 16'h6996);
        chk("both_rbv", bus.readback_valid, 1'b0);
        for (int i = 0; i < 16; i++) probe(4'(i));
        bus.cfg_start = 1'b1;
        tick();
        quiet();
        for (int i = 0; i < 9; i++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_bit   = 1'($urandom);
            tick();
            quiet();
        end
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_ready", bus.cfg_ready, 1'b0);
        chk("mid_rst_y", bus.y, 1'b0);
        chk("mid_rst_readback", bus.readback, 16'h0);
        rst = 1'b0;
        ref_table = INIT;
        ref_rb    = '0;
        ref_rbv   = 1'b0;
        for (int i = 0; i < 16; i++) probe(4'(i));
        load(16'hFFFF, 0, 1'b0);
        for (int i = 0; i < 16; i++) probe(4'(i));
        scan();
        scan();
        for (int r = 0; r < 8; r++) begin
            load(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
            for (int i = 0; i < 6; i++) probe(4'($urandom));
            if ($urandom_range(0, 1) == 1) scan();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
